// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, single-outstanding instruction
// memory handshake, skid buffer and IF/ID pipeline register.
// Optional build macro FETCH_PERF_CNT_EN adds saturating stall/flush counters;
// without it perf_stall_cycles and perf_flushes are tied to zero.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | first cycle after reset, no request yet
// REQ   | request for pc presented (held off while pc_write=0)
// WAIT  | request accepted, waiting for imem_valid
// HOLD  | response parked in skid buffer until both stalls release
module mips_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ctrl_hazard_pc_write,
    input  logic        ctrl_hazard_if_id_write,
    input  logic        ctrl_redirect,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flushes
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] if_id_pc4_q, if_id_pc4_d;
    logic        if_id_valid_q, if_id_valid_d;
    // Skid buffer contents are only meaningful in HOLD, so HOLD doubles as
    // the buffer-occupied flag.
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;
    logic        discard_q, discard_d;

    logic [31:0] pc_plus4;
    logic        stall_free;
    logic        req_fire;

    assign pc_plus4   = pc_q + 32'd4;
    assign stall_free = ctrl_hazard_pc_write && ctrl_hazard_if_id_write;
    assign req_fire   = imem_req && imem_ready;

    assign imem_req    = (state_q == ST_REQ) && ctrl_hazard_pc_write;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign if_id_pc4   = if_id_pc4_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_valid = if_id_valid_q;

    // Next-state, PC, IF/ID and skid buffer update; redirect overrides last.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc4_d   = if_id_pc4_q;
        if_id_valid_d = if_id_valid_q;
        skid_instr_d  = skid_instr_q;
        skid_pc4_d    = skid_pc4_q;
        discard_d     = discard_q;

        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (req_fire) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_valid) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = ST_REQ;
                    end else if (stall_free) begin
                        if_id_instr_d = imem_rdata;
                        if_id_pc4_d   = pc_plus4;
                        if_id_valid_d = 1'b1;
                        pc_d          = pc_plus4;
                        state_d       = ST_REQ;
                    end else begin
                        skid_instr_d = imem_rdata;
                        skid_pc4_d   = pc_plus4;
                        state_d      = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (stall_free) begin
                    if_id_instr_d = skid_instr_q;
                    if_id_pc4_d   = skid_pc4_q;
                    if_id_valid_d = 1'b1;
                    pc_d          = pc_plus4;
                    state_d       = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (ctrl_redirect) begin
            pc_d          = redirect_target & 32'hFFFF_FFFC;
            if_id_instr_d = NOP_WORD;
            if_id_valid_d = 1'b0;
            case (state_q)
                ST_WAIT: begin
                    // A response arriving this very cycle retires the only
                    // outstanding request, so nothing is left to discard.
                    if (imem_valid) begin
                        discard_d = 1'b0;
                        state_d   = ST_REQ;
                    end else begin
                        discard_d = 1'b1;
                        state_d   = ST_WAIT;
                    end
                end
                ST_REQ: begin
                    if (req_fire) begin
                        discard_d = 1'b1;
                        state_d   = ST_WAIT;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    // Fetch state, PC and pipeline register flops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            if_id_instr_q <= NOP_WORD;
            if_id_pc4_q   <= 32'd0;
            if_id_valid_q <= 1'b0;
            skid_instr_q  <= 32'd0;
            skid_pc4_q    <= 32'd0;
            discard_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_valid_q <= if_id_valid_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc4_q    <= skid_pc4_d;
            discard_q     <= discard_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    // Saturating event counters.
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if ((!ctrl_hazard_pc_write || !ctrl_hazard_if_id_write) && (perf_stall_q != 32'hFFFF_FFFF))
            perf_stall_d = perf_stall_q + 32'd1;
        if (ctrl_redirect && (perf_flush_q != 32'hFFFF_FFFF))
            perf_flush_d = perf_flush_q + 32'd1;
    end

    // Counter flops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flushes      = perf_flush_q;
`else
    assign perf_stall_cycles = 32'd0;
    assign perf_flushes      = 32'd0;
`endif

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Bench for mips_fetch_stage: directed scenarios plus a randomized run
// checked against a transaction-level model of the fetch stream.
module tb_mips_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0000;
`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic        clock;
    logic        reset_n;
    logic        pc_write, ifw, redirect;
    logic [31:0] target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready, imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] pc, if_id_pc4, if_id_instr;
    logic        if_id_valid;
    logic [31:0] perf_stall_cycles, perf_flushes;

    int vectors = 0;
    int miscompares = 0;
    int exp_stall, exp_flush;

    // memory model state
    bit          pending;
    logic [31:0] paddr;
    int          pdelay;
    int          lat_cfg;
    bit          ovr_en;
    logic [31:0] ovr_data;

    mips_fetch_stage #(.RESET_PC(RST_PC), .NOP_WORD(NOP)) dut (
        .clock                   (clock),
        .reset_n                 (reset_n),
        .ctrl_hazard_pc_write    (pc_write),
        .ctrl_hazard_if_id_write (ifw),
        .ctrl_redirect           (redirect),
        .redirect_target         (target),
        .imem_req                (imem_req),
        .imem_addr               (imem_addr),
        .imem_ready              (imem_ready),
        .imem_valid              (imem_valid),
        .imem_rdata              (imem_rdata),
        .pc                      (pc),
        .if_id_pc4               (if_id_pc4),
        .if_id_instr             (if_id_instr),
        .if_id_valid             (if_id_valid),
        .perf_stall_cycles       (perf_stall_cycles),
        .perf_flushes            (perf_flushes)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hAAAA_0000 + a;
    endfunction

    task automatic set_defaults();
        pc_write   = 1'b1;
        ifw        = 1'b1;
        redirect   = 1'b0;
        target     = 32'd0;
        imem_ready = 1'b1;
        lat_cfg    = 0;
    endtask

    task automatic do_reset();
        set_defaults();
        reset_n    = 1'b0;
        imem_valid = 1'b0;
        imem_rdata = 32'd0;
        pending    = 1'b0;
        ovr_en     = 1'b0;
        exp_stall  = 0;
        exp_flush  = 0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    // One clock cycle: entered and left at a falling edge; models memory.
    task automatic tick();
        logic        acc;
        logic [31:0] aaddr;
        logic        fire;
        #1;
        acc   = imem_req && imem_ready;
        aaddr = imem_addr;
        fire  = imem_valid;
        if (!pc_write || !ifw) exp_stall++;
        if (redirect) exp_flush++;
        @(posedge clock);
        @(negedge clock);
        if (fire) pending = 1'b0;
        if (acc) begin
            vectors++;
            if (pending) begin
                $display("FAIL outstanding: second request at %h while one pending, allowed 1", aaddr);
                miscompares++;
            end
            pending = 1'b1;
            paddr   = aaddr;
            pdelay  = lat_cfg;
        end
        imem_valid = 1'b0;
        imem_rdata = $urandom;
        if (pending) begin
            if (pdelay == 0) begin
                imem_valid = 1'b1;
                imem_rdata = ovr_en ? ovr_data : mem_word(paddr);
                ovr_en     = 1'b0;
            end else begin
                pdelay--;
            end
        end
    endtask

    task automatic wait_req(input int max_cycles);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cycles && !ok; i++) begin
            #1;
            if (imem_req) ok = 1'b1;
            else tick();
        end
        vectors++;
        if (!ok) begin
            $display("FAIL wait_req: imem_req got 0 after %0d cycles, want 1", max_cycles);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        set_defaults();
        reset_n = 1'b0; imem_valid = 1'b0; imem_rdata = 32'd0;
        pending = 1'b0; ovr_en = 1'b0; exp_stall = 0; exp_flush = 0;
        repeat (2) @(negedge clock);
        #1;
        vectors++; if (pc !== RST_PC) begin $display("FAIL rst_pc: got %h want %h", pc, RST_PC); miscompares++; end
        vectors++; if (imem_req !== 1'b0) begin $display("FAIL rst_req: got %b want 0", imem_req); miscompares++; end
        vectors++; if (if_id_instr !== NOP) begin $display("FAIL rst_instr: got %h want %h", if_id_instr, NOP); miscompares++; end
        vectors++; if (if_id_pc4 !== 32'd0) begin $display("FAIL rst_pc4: got %h want 0", if_id_pc4); miscompares++; end
        vectors++; if (if_id_valid !== 1'b0) begin $display("FAIL rst_valid: got %b want 0", if_id_valid); miscompares++; end
        vectors++; if (perf_stall_cycles !== 32'd0 || perf_flushes !== 32'd0) begin
            $display("FAIL rst_perf: got %h/%h want 0/0", perf_stall_cycles, perf_flushes); miscompares++; end
        reset_n = 1'b1;
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 3; k++) begin
            logic [31:0] a;
            a = RST_PC + 32'(4 * k);
            wait_req(10);
            vectors++; if (imem_addr !== a) begin $display("FAIL seq_addr: got %h want %h", imem_addr, a); miscompares++; end
            tick();
            tick();
            vectors++; if (if_id_instr !== mem_word(a)) begin $display("FAIL seq_instr: got %h want %h", if_id_instr, mem_word(a)); miscompares++; end
            vectors++; if (if_id_pc4 !== a + 32'd4) begin $display("FAIL seq_pc4: got %h want %h", if_id_pc4, a + 32'd4); miscompares++; end
            vectors++; if (if_id_valid !== 1'b1) begin $display("FAIL seq_valid: got %b want 1", if_id_valid); miscompares++; end
            vectors++; if (pc !== a + 32'd4) begin $display("FAIL seq_pc: got %h want %h", pc, a + 32'd4); miscompares++; end
        end
    endtask

    task automatic test_stall();
        do_reset();
        wait_req(10); tick(); tick();
        wait_req(10);
        vectors++; if (imem_addr !== 32'h104) begin $display("FAIL stall_addr: got %h want 104", imem_addr); miscompares++; end
        ovr_en = 1'b1; ovr_data = 32'h8C22_0004;
        tick();
        pc_write = 1'b0; ifw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (if_id_instr !== mem_word(32'h100) || if_id_pc4 !== 32'h104 || if_id_valid !== 1'b1) begin
                $display("FAIL stall_ifid: got %h/%h/%b want %h/104/1", if_id_instr, if_id_pc4, if_id_valid, mem_word(32'h100)); miscompares++; end
            vectors++; if (pc !== 32'h104) begin $display("FAIL stall_pc: got %h want 104", pc); miscompares++; end
            vectors++; if (imem_req !== 1'b0) begin $display("FAIL stall_req: got %b want 0", imem_req); miscompares++; end
        end
        pc_write = 1'b1; ifw = 1'b1;
        tick();
        vectors++; if (if_id_instr !== 32'h8C22_0004) begin $display("FAIL stall_rel_instr: got %h want 8c220004", if_id_instr); miscompares++; end
        vectors++; if (if_id_pc4 !== 32'h108 || pc !== 32'h108) begin $display("FAIL stall_rel_pc: got %h/%h want 108/108", if_id_pc4, pc); miscompares++; end
    endtask

    task automatic test_redirect();
        wait_req(10);
        vectors++; if (imem_addr !== 32'h108) begin $display("FAIL redir_pre_addr: got %h want 108", imem_addr); miscompares++; end
        lat_cfg = 2;
        tick();
        lat_cfg = 0;
        redirect = 1'b1; target = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        vectors++; if (pc !== 32'h200) begin $display("FAIL redir_pc: got %h want 200", pc); miscompares++; end
        vectors++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin
            $display("FAIL redir_flush: got %b/%h want 0/%h", if_id_valid, if_id_instr, NOP); miscompares++; end
        tick();
        vectors++; if (imem_req !== 1'b0) begin $display("FAIL redir_wait_req: got %b want 0", imem_req); miscompares++; end
        tick();
        vectors++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP || pc !== 32'h200) begin
            $display("FAIL redir_drop: got %b/%h/%h want 0/%h/200", if_id_valid, if_id_instr, pc, NOP); miscompares++; end
        wait_req(3);
        vectors++; if (imem_addr !== 32'h200) begin $display("FAIL redir_addr: got %h want 200", imem_addr); miscompares++; end
        tick(); tick();
        vectors++; if (if_id_instr !== mem_word(32'h200) || if_id_pc4 !== 32'h204) begin
            $display("FAIL redir_fetch: got %h/%h want %h/204", if_id_instr, if_id_pc4, mem_word(32'h200)); miscompares++; end
    endtask

    task automatic test_redirect_stall();
        pc_write = 1'b0; ifw = 1'b0; redirect = 1'b1; target = 32'h0000_0300;
        tick();
        set_defaults();
        vectors++; if (pc !== 32'h300) begin $display("FAIL rs_pc: got %h want 300", pc); miscompares++; end
        vectors++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin
            $display("FAIL rs_flush: got %b/%h want 0/%h", if_id_valid, if_id_instr, NOP); miscompares++; end
        wait_req(5);
        vectors++; if (imem_addr !== 32'h300) begin $display("FAIL rs_addr: got %h want 300", imem_addr); miscompares++; end
    endtask

    task automatic test_wrap();
        logic [31:0] top;
        top = 32'hFFFF_FFFC;
        redirect = 1'b1; target = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0;
        wait_req(6);
        vectors++; if (imem_addr !== top) begin $display("FAIL wrap_addr: got %h want %h", imem_addr, top); miscompares++; end
        tick(); tick();
        vectors++; if (pc !== 32'd0 || if_id_pc4 !== 32'd0) begin $display("FAIL wrap_pc: got %h/%h want 0/0", pc, if_id_pc4); miscompares++; end
        vectors++; if (if_id_instr !== mem_word(top) || if_id_valid !== 1'b1) begin
            $display("FAIL wrap_instr: got %h/%b want %h/1", if_id_instr, if_id_valid, mem_word(top)); miscompares++; end
    endtask

    task automatic test_reset_mid_wait();
        wait_req(5);
        lat_cfg = 3;
        tick();
        lat_cfg = 0;
        #2 reset_n = 1'b0;
        #1;
        vectors++; if (pc !== RST_PC || imem_req !== 1'b0) begin $display("FAIL arst_pc: got %h/%b want %h/0", pc, imem_req, RST_PC); miscompares++; end
        vectors++; if (if_id_instr !== NOP || if_id_pc4 !== 32'd0 || if_id_valid !== 1'b0) begin
            $display("FAIL arst_ifid: got %h/%h/%b want %h/0/0", if_id_instr, if_id_pc4, if_id_valid, NOP); miscompares++; end
        pending = 1'b0; exp_stall = 0; exp_flush = 0;
        @(negedge clock);
        reset_n = 1'b1;
        imem_ready = 1'b0;
        imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        vectors++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP || pc !== RST_PC) begin
            $display("FAIL stale_valid: got %b/%h/%h want 0/%h/%h", if_id_valid, if_id_instr, pc, NOP, RST_PC); miscompares++; end
        imem_ready = 1'b1;
        wait_req(5);
        tick(); tick();
        vectors++; if (if_id_instr !== mem_word(RST_PC) || if_id_valid !== 1'b1) begin
            $display("FAIL arst_refetch: got %h/%b want %h/1", if_id_instr, if_id_valid, mem_word(RST_PC)); miscompares++; end
        pc_write = 1'b0;
        repeat (3) tick();
        pc_write = 1'b1; redirect = 1'b1; target = 32'h400;
        tick();
        redirect = 1'b0;
        vectors++; if (perf_stall_cycles !== (PERF_EN ? 32'(exp_stall) : 32'd0)) begin
            $display("FAIL perf_stall: got %0d want %0d", perf_stall_cycles, PERF_EN ? exp_stall : 0); miscompares++; end
        vectors++; if (perf_flushes !== (PERF_EN ? 32'(exp_flush) : 32'd0)) begin
            $display("FAIL perf_flush: got %0d want %0d", perf_flushes, PERF_EN ? exp_flush : 0); miscompares++; end
    endtask

    // Transaction-level model: pc only moves by redirect (to the aligned
    // target, flushing IF/ID) or by delivering mem_word(pc) into IF/ID.
    task automatic test_random();
        logic [31:0] p_pc, p_instr, p_pc4, p_tgt;
        logic        p_valid, p_redir, p_open;
        int          delivered;
        delivered = 0;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            pc_write   = ($urandom_range(0, 3) != 0);
            ifw        = ($urandom_range(0, 3) != 0);
            redirect   = ($urandom_range(0, 19) == 0);
            target     = $urandom;
            imem_ready = ($urandom_range(0, 9) < 7);
            lat_cfg    = $urandom_range(0, 3);
            #1;
            vectors++; if (imem_req && imem_addr !== pc) begin $display("FAIL rnd_addr: got %h want %h", imem_addr, pc); miscompares++; end
            vectors++; if (!pc_write && imem_req) begin $display("FAIL rnd_req_stall: got 1 want 0"); miscompares++; end
            p_pc = pc; p_instr = if_id_instr; p_pc4 = if_id_pc4; p_valid = if_id_valid;
            p_redir = redirect; p_tgt = target; p_open = pc_write && ifw;
            tick();
            vectors++;
            if (p_redir) begin
                if (pc !== (p_tgt & 32'hFFFF_FFFC) || if_id_valid !== 1'b0 || if_id_instr !== NOP) begin
                    $display("FAIL rnd_redirect: got %h/%b/%h want %h/0/%h", pc, if_id_valid, if_id_instr, p_tgt & 32'hFFFF_FFFC, NOP);
                    miscompares++;
                end
            end else if (pc === p_pc) begin
                if (if_id_instr !== p_instr || if_id_pc4 !== p_pc4 || if_id_valid !== p_valid) begin
                    $display("FAIL rnd_hold: got %h/%h/%b want %h/%h/%b", if_id_instr, if_id_pc4, if_id_valid, p_instr, p_pc4, p_valid);
                    miscompares++;
                end
            end else begin
                delivered++;
                if (!p_open || pc !== p_pc + 32'd4 || if_id_valid !== 1'b1 || if_id_pc4 !== pc || if_id_instr !== mem_word(p_pc)) begin
                    $display("FAIL rnd_deliver: got pc %h pc4 %h instr %h v %b open %b want pc %h instr %h v 1 open 1",
                             pc, if_id_pc4, if_id_instr, if_id_valid, p_open, p_pc + 32'd4, mem_word(p_pc));
                    miscompares++;
                end
            end
        end
        vectors++; if (delivered < 30) begin $display("FAIL rnd_progress: got %0d deliveries want >= 30", delivered); miscompares++; end
        vectors++; if (perf_stall_cycles !== (PERF_EN ? 32'(exp_stall) : 32'd0) || perf_flushes !== (PERF_EN ? 32'(exp_flush) : 32'd0)) begin
            $display("FAIL rnd_perf: got %0d/%0d want %0d/%0d", perf_stall_cycles, perf_flushes,
                     PERF_EN ? exp_stall : 0, PERF_EN ? exp_flush : 0);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mips_fetch_stage.md
Name: mips_fetch_stage

Overview:
- Consumer of the hazard unit's stall/flush controls: owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register.
- Honours PC-write and IF/ID-write stalls without losing in-flight instruction data, and flushes on branch/jump redirects.
- Sits between instruction memory and the decode stage; feeds IF/ID outputs to decode and the hazard unit.

Parameters:
- RESET_PC, 32'h00000000: PC value loaded on reset.
- NOP_WORD, 32'h00000000: instruction word driven into IF/ID on flush or bubble (sll $0,$0,0).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- ctrl_hazard_pc_write  in  1  1 = PC may advance.
- ctrl_hazard_if_id_write  in  1  1 = IF/ID may load.
- ctrl_redirect  in  1  branch taken / jump; flush IF and load target.
- redirect_target  in  32  new PC when ctrl_redirect=1.
- imem_req  out  1  request valid.
- imem_addr  out  32  word-aligned fetch address.
- imem_ready  in  1  memory accepts request this cycle.
- imem_valid  in  1  response data valid (at least 1 cycle after accept).
- imem_rdata  in  32  instruction word.
- pc  out  32  current fetch PC.
- if_id_pc4  out  32  PC+4 of instruction in IF/ID.
- if_id_instr  out  32  instruction in IF/ID.
- if_id_valid  out  1  IF/ID holds a real instruction.
- perf_stall_cycles  out  32  optional-feature counter.
- perf_flushes  out  32  optional-feature counter.

Behaviour:
- Reset (async, reset_n=0): pc=RESET_PC, imem_req=0, if_id_instr=NOP_WORD, if_id_pc4=0, if_id_valid=0, skid buffer empty, discard flag 0, counters 0, state IDLE.
- At most one outstanding request; imem_addr=pc while imem_req=1; request completes on imem_req & imem_ready.
- States:
  - IDLE: first cycle after reset; -> REQ.
  - REQ: imem_req=1; on ready -> WAIT.
  - WAIT: imem_req=0; on imem_valid, as follows:
    - Discard flag set: drop the data, clear the flag, -> REQ.
    - Both stalls released: load IF/ID (instr=rdata, pc4=pc+4, valid=1), pc<=pc+4, -> REQ.
    - Otherwise: capture rdata/pc+4 in the skid buffer, -> HOLD.
  - HOLD: imem_req=0; when pc_write=1 and if_id_write=1, move the skid buffer to IF/ID, pc<=pc+4, empty the buffer, -> REQ.
- Fetch-to-IF/ID latency: 1 cycle after imem_valid when not stalled; throughput 1 instruction per 2 cycles with a zero-wait memory.
- if_id_write=0: IF/ID holds its value exactly (instr, pc4, valid).
- pc_write=0: pc holds; no new request issued (REQ deasserts imem_req and waits).
- Redirect (priority over stall), same edge:
  - pc<=redirect_target; IF/ID <= NOP_WORD, valid=0; skid buffer emptied.
  - In WAIT: set discard flag and stay in WAIT.
  - In REQ with ready=1 the same cycle: accept the request, set the discard flag, -> WAIT.
  - Otherwise: -> REQ.
- Redirect during the discard cycle itself: the target overrides again, and the discard flag stays set until the single outstanding response returns.
- imem_valid outside WAIT is ignored.
- pc, pc+4 and target arithmetic is 32-bit modulo and wraps from 32'hFFFFFFFC to 0; bits [1:0] of redirect_target are forced to 0.

Optional Feature:
- FETCH_PERF_CNT_EN defined:
  - perf_stall_cycles increments each cycle that pc_write=0 or if_id_write=0.
  - perf_flushes increments each cycle that ctrl_redirect=1.
  - Both saturate at 32'hFFFFFFFF.
- Not defined: both outputs tied to 0 and no counter flops.

Test Plan:
- Reset with RESET_PC=32'h100, zero-wait memory returning 32'hAAAA0000+addr -> imem_addr 0x100, 0x104, 0x108; if_id_instr tracks each; if_id_valid=1 from the first response.
- pc_write=if_id_write=0 for 3 cycles asserted while in WAIT, response 32'h8C220004 -> IF/ID unchanged during the stall, pc held at 0x104, no imem_req; one cycle after release IF/ID=32'h8C220004, pc4=0x108.
- ctrl_redirect=1, target=32'h0000_0200 in WAIT, old response arrives 2 cycles later -> old data dropped, if_id_valid=0 and instr=NOP_WORD; next imem_addr=0x200.
- Redirect and stall asserted simultaneously -> redirect wins: pc=target, IF/ID flushed.
- pc=32'hFFFFFFFC fetch completes -> pc wraps to 0, if_id_pc4=0.
- reset_n pulsed low mid-WAIT -> all outputs at reset values immediately (asynchronous); a stale imem_valid afterward is ignored. With FETCH_PERF_CNT_EN: 3 stall cycles plus 1 redirect -> counters 3 and 1.
